unit_arbiter: RTL

UNIT_ARBITER -- requirements
Module: unit_arbiter

---
 rtl/unit_arb_pkg.sv | 18 +
 rtl/unit_arbiter_if.sv | 37 +++
 rtl/unit_arbiter_rr_pick.sv | 35 +++
 rtl/unit_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/unit_arb_pkg.sv
// Shared types and constants for the unit arbiter: FSM states, default timeout,
// and the index-width helper used by the interface and the RTL.
package unit_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam int TMO_DEFAULT = 15;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unit_arbiter_if.sv
// Request, shared-unit and response signals of the unit arbiter.
// slave = arbiter side, master = requesters / unit / response consumer.
interface unit_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int RW   = 3
);
    import unit_arb_pkg::*;

    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               unit_start;
    logic [DW-1:0]      unit_x;
    logic               unit_done;
    logic [RW-1:0]      unit_y;
    logic               unit_z;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [RW-1:0]      rsp_y;
    logic               rsp_z;
    logic               rsp_err;

    modport slave (
        input  req_valid, req_data, unit_done, unit_y, unit_z, rsp_ready,
        output req_ready, unit_start, unit_x, rsp_valid, rsp_id, rsp_y, rsp_z, rsp_err
    );

    modport master (
        output req_valid, req_data, unit_done, unit_y, unit_z, rsp_ready,
        input  req_ready, unit_start, unit_x, rsp_valid, rsp_id, rsp_y, rsp_z, rsp_err
    );

endinterface

// File: rtl/unit_arbiter_rr_pick.sv
// Round-robin select: first requester after i_last (wrapping), one-hot and index.
// Purely combinational; o_any flags that some request is present.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [IW-1:0] w_cand;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        // Visit last+1 .. last+NREQ so the previous winner is checked last.
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IW'((int'(i_last) + i) % NREQ);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/unit_arbiter.sv
// Shares one multi-cycle unit among NREQ requesters, one transaction at a time.
// Accept->rsp_valid min 3 cycles; response held until rsp_ready, no grants meanwhile.
module unit_arbiter
    import unit_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int RW   = 3,
    parameter int TMO  = TMO_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    unit_arbiter_if.slave  bus
);

    localparam int         IW       = idx_w(NREQ);
    localparam logic [7:0] CNT_LAST = 8'(TMO - 1);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [IW-1:0]   r_last;
    logic [DW-1:0]   r_x;
    logic [IW-1:0]   r_id;
    logic [RW-1:0]   r_y;
    logic            r_z;
    logic            r_err;
    logic [7:0]      r_cnt;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic            w_done;
    logic            w_tmo;
    logic [NREQ-1:0] w_req_ready;
    logic            w_unit_start;
    logic            w_rsp_valid;
    logic [DW-1:0]   w_ops [NREQ];

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req   (bus.req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_ops[i] = bus.req_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_done       = 1'b0;
        w_tmo        = 1'b0;
        w_req_ready  = '0;
        w_unit_start = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = w_grant;
                if (w_any) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_unit_start = 1'b1;
                w_state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                // A done landing on the final count still counts as success.
                w_done = bus.unit_done;
                w_tmo  = !bus.unit_done && (r_cnt == CNT_LAST);
                if (w_done || w_tmo) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (rst) begin
            w_req_ready  = '0;
            w_unit_start = 1'b0;
            w_rsp_valid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= IW'(NREQ - 1);
            r_x    <= '0;
            r_id   <= '0;
            r_y    <= '0;
            r_z    <= 1'b0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_last <= w_idx;
                        r_id   <= w_idx;
                        r_x    <= w_ops[w_idx];
                    end
                end
                ST_ISSUE: r_cnt <= '0;
                ST_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_done) begin
                        r_y   <= bus.unit_y;
                        r_z   <= bus.unit_z;
                        r_err <= 1'b0;
                    end else if (w_tmo) begin
                        r_y   <= '0;
                        r_z   <= 1'b0;
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.unit_start = w_unit_start;
    assign bus.unit_x     = r_x;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_y      = r_y;
    assign bus.rsp_z      = r_z;
    assign bus.rsp_err    = r_err;

endmodule
